mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multicycle MIPS controller: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB over one shared ALU and one
//  shared instr/data memory with a req/ready handshake. Replaces the single-cycle main_control/pc enable
//  path; drives the multicycle datapath (IR, A/B, ALUOut, MDR regs). Adds bne, memory wait states,
//  a wait-timeout and an illegal-opcode trap.
// PARAMETERS
//  MEM_HANDSHAKE  1   1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
//  WAIT_LIMIT     16  max consecutive mem_ready=0 cycles in one memory state; 0 disables timeout
//  CNT_W          5   wait counter width; must satisfy 2**CNT_W > WAIT_LIMIT
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  op         in   6   IR[31:26]; must be stable from DECODE onward
//  zero       in   1   ALU zero flag
//  mem_ready  in   1   memory completes the current access this cycle
//  mem_req    out  1   memory access request
//  iord       out  1   mem address: 0=PC, 1=ALUOut
//  memwrite   out  1   memory write strobe
//  irwrite    out  1   load IR
//  regdst     out  1   write reg: 0=rt, 1=rd
//  memtoreg   out  1   write data: 0=ALUOut, 1=MDR
//  regwrite   out  1   regfile write enable
//  alusrca    out  1   ALU A: 0=PC, 1=A reg
//  alusrcb    out  2   ALU B: 00=B reg, 01=4, 10=signext imm, 11=signext imm<<2
//  aluop      out  2   00 add, 01 sub, 10 funct, 11 or (alu_control encoding)
//  pcsrc      out  2   00=ALU result, 01=ALUOut, 10=jump target
//  pcen       out  1   PC load enable (branch condition already folded in)
//  err        out  1   sticky error flag
//  state      out  4   current state, debug
// BEHAVIOUR
//  - rst=0: state<=FETCH, op_q<=0, wait_cnt<=0, err<=0; all other outputs forced 0 while rst=0.
//  - State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7,
//    BREX 8, IMMEX 9, IMMWB 10, JEX 11, ERROR 15; codes 12-14 unreachable, go to ERROR.
//  - Outputs decoded from state only (plus mem_ready, zero, op_q where noted); unlisted outputs are 0.
//  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcen=rdy.
//    Leaves to DECODE when rdy; rdy = mem_ready if MEM_HANDSHAKE else 1.
//  - DECODE: alusrca=0, alusrcb=11, aluop=00; op_q<=op. Next: lw/sw(100011/101011)->MEMADR,
//    R(000000)->RTYPEEX, beq/bne(000100/000101)->BREX, addi/ori(001000/001101)->IMMEX,
//    j(000010)->JEX, any other op->ERROR.
//  - MEMADR: alusrca=1, alusrcb=10, aluop=00; lw->MEMRD, sw->MEMWR.
//  - MEMRD: mem_req=1, iord=1; rdy->MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0; ->FETCH.
//  - MEMWR: mem_req=1, iord=1, memwrite=1 (held until rdy); rdy->FETCH.
//  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10; ->ALUWB. ALUWB: regwrite=1, regdst=1; ->FETCH.
//  - BREX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01; pcen = zero (beq) / ~zero (bne, op_q[0]=1); ->FETCH.
//  - IMMEX: alusrca=1, alusrcb=10, aluop=00 (addi) / 11 (ori); ->IMMWB.
//    IMMWB: regwrite=1, regdst=0, memtoreg=0; ->FETCH.
//  - JEX: pcsrc=10, pcen=1; ->FETCH.
//  - Latency with zero wait: beq/bne/j 3, R/addi/ori/sw 4, lw 5 cycles; each wait cycle adds 1.
//  - wait_cnt: clears on every state change; in FETCH/MEMRD/MEMWR increments each cycle with rdy=0.
//    WAIT_LIMIT>0 and rdy=0 with wait_cnt==WAIT_LIMIT-1 -> ERROR next edge (timeout on the LIMIT-th
//    wait cycle). mem_ready arriving on that same cycle wins: normal completion, no error.
//  - ERROR: err=1, all strobes 0, mem_req=0; stays until rst=0. Reset mid-instruction aborts silently.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
// TESTING
//  - Reset, MEM_HANDSHAKE=1, mem_ready=1, op=000000: states 0,1,6,7,0; regwrite=1, regdst=1 only in ALUWB.
//  - op=100011, mem_ready low 3 cycles in MEMRD: stays in 3 for 4 cycles, MEMWB once, lw = 8 cycles.
//  - op=000101 zero=0 -> pcen=1 in BREX; zero=1 -> pcen=0; op=000100 gives inverse results.
//  - WAIT_LIMIT=16, mem_ready=0 forever in FETCH: ERROR after 16 wait cycles, err=1 held; ready on the
//    16th cycle instead -> DECODE, err=0.
//  - op=111111 in DECODE -> ERROR, err=1, all strobes 0; rst low mid-MEMWR -> memwrite drops immediately.
//  - MEM_HANDSHAKE=0, mem_ready=0 tied: sw runs 0,1,2,5,0 with memwrite=1 for exactly one cycle.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// Handshake: mem_req stays high (with iord/memwrite stable) until a cycle where mem_ready is high; that cycle completes the access.
interface mips_multicycle_control_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       err;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, err, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsrc, pcen, err, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore FSM sequencing a multicycle MIPS datapath: fetch/decode/execute/memory/writeback over
// one shared ALU and memory, with memory wait states, a wait timeout and an illegal-opcode trap.
module mips_multicycle_control #(
    parameter int          MEM_HANDSHAKE = 1,
    parameter int unsigned WAIT_LIMIT    = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    mips_multicycle_control_if.master ctl
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BREX    = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_ERROR   = 4'd15
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q;
    logic             rdy;
    logic             mem_state;
    logic             timeout;

    assign rdy       = (MEM_HANDSHAKE != 0) ? ctl.mem_ready : 1'b1;
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready arriving on the last allowed wait cycle completes normally, so timeout needs rdy=0.
    assign timeout   = (WAIT_LIMIT != 0) && mem_state && !rdy &&
                       (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_RTYPEEX;
                    OP_BEQ, OP_BNE:   state_d = S_BREX;
                    OP_ADDI, OP_ORI:  state_d = S_IMMEX;
                    OP_J:             state_d = S_JEX;
                    default:          state_d = S_ERROR;
                endcase
            end
            S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (rdy) state_d = S_MEMWB;
            S_MEMWR:   if (rdy) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_ALUWB;
            S_IMMEX:   state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BREX, S_IMMWB, S_JEX: state_d = S_FETCH;
            S_ERROR:   state_d = S_ERROR;
            default:   state_d = S_ERROR;
        endcase
        if (timeout) state_d = S_ERROR;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) wait_cnt_d = '0;
        else if (mem_state && !rdy) wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_q | (state_d == S_ERROR);
            if (state_q == S_DECODE) op_q <= ctl.op;
        end
    end

    // Decode is gated by rst so nothing strobes while reset is held, even though FETCH is code 0.
    always_comb begin
        ctl.mem_req  = 1'b0;
        ctl.iord     = 1'b0;
        ctl.memwrite = 1'b0;
        ctl.irwrite  = 1'b0;
        ctl.regdst   = 1'b0;
        ctl.memtoreg = 1'b0;
        ctl.regwrite = 1'b0;
        ctl.alusrca  = 1'b0;
        ctl.alusrcb  = 2'b00;
        ctl.aluop    = 2'b00;
        ctl.pcsrc    = 2'b00;
        ctl.pcen     = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    ctl.mem_req = 1'b1;
                    ctl.alusrcb = 2'b01;
                    ctl.irwrite = rdy;
                    ctl.pcen    = rdy;
                end
                S_DECODE:  ctl.alusrcb = 2'b11;
                S_MEMADR: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    ctl.mem_req = 1'b1;
                    ctl.iord    = 1'b1;
                end
                S_MEMWB: begin
                    ctl.regwrite = 1'b1;
                    ctl.memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    ctl.mem_req  = 1'b1;
                    ctl.iord     = 1'b1;
                    ctl.memwrite = 1'b1;
                end
                S_RTYPEEX: begin
                    ctl.alusrca = 1'b1;
                    ctl.aluop   = 2'b10;
                end
                S_ALUWB: begin
                    ctl.regwrite = 1'b1;
                    ctl.regdst   = 1'b1;
                end
                S_BREX: begin
                    ctl.alusrca = 1'b1;
                    ctl.aluop   = 2'b01;
                    ctl.pcsrc   = 2'b01;
                    ctl.pcen    = op_q[0] ? ~ctl.zero : ctl.zero;
                end
                S_IMMEX: begin
                    ctl.alusrca = 1'b1;
                    ctl.alusrcb = 2'b10;
                    ctl.aluop   = (op_q == OP_ORI) ? 2'b11 : 2'b00;
                end
                S_IMMWB:   ctl.regwrite = 1'b1;
                S_JEX: begin
                    ctl.pcsrc = 2'b10;
                    ctl.pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctl.state = state_q;
    assign ctl.err   = err_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: two instances (handshake on / off) checked every cycle
// against an instruction-plan model, plus directed sequences with hand-computed expectations.
module tb_mips_multicycle_control;
    localparam int P_FETCH = 0, P_DEC = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4, P_MEMWR = 5;
    localparam int P_REX = 6, P_ALUWB = 7, P_BREX = 8, P_IMMEX = 9, P_IMMWB = 10, P_JEX = 11, P_ERR = 15;
    localparam int B_MEMWRITE = 17, B_REGDST = 15, B_REGWRITE = 13, B_PCEN = 5, B_ERR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n[2]  = '{1'b0, 1'b0};
    logic [5:0]  op_v[2]   = '{6'd0, 6'd0};
    logic        zero_v[2] = '{1'b0, 1'b0};
    logic        rdy_v[2]  = '{1'b1, 1'b1};
    logic [19:0] out_v[2];
    logic [19:0] last_out[2];

    int n_chk = 0;
    int n_fail = 0;

    mips_multicycle_control_if if_a();
    mips_multicycle_control_if if_b();

    assign if_a.op = op_v[0];
    assign if_a.zero = zero_v[0];
    assign if_a.mem_ready = rdy_v[0];
    assign if_b.op = op_v[1];
    assign if_b.zero = zero_v[1];
    assign if_b.mem_ready = rdy_v[1];

    assign out_v[0] = {if_a.mem_req, if_a.iord, if_a.memwrite, if_a.irwrite, if_a.regdst, if_a.memtoreg,
                       if_a.regwrite, if_a.alusrca, if_a.alusrcb, if_a.aluop, if_a.pcsrc, if_a.pcen,
                       if_a.err, if_a.state};
    assign out_v[1] = {if_b.mem_req, if_b.iord, if_b.memwrite, if_b.irwrite, if_b.regdst, if_b.memtoreg,
                       if_b.regwrite, if_b.alusrca, if_b.alusrcb, if_b.aluop, if_b.pcsrc, if_b.pcen,
                       if_b.err, if_b.state};

    mips_multicycle_control #(.MEM_HANDSHAKE(1), .WAIT_LIMIT(16), .CNT_W(5)) dut_a (
        .clk(clk), .rst(rst_n[0]), .ctl(if_a)
    );
    mips_multicycle_control #(.MEM_HANDSHAKE(0), .WAIT_LIMIT(16), .CNT_W(5)) dut_b (
        .clk(clk), .rst(rst_n[1]), .ctl(if_b)
    );

    // ---------------- behavioural model ----------------
    int          hs[2]  = '{1, 0};
    int          lim[2] = '{16, 16};
    int          m_ph[2] = '{0, 0};
    int          m_wait[2] = '{0, 0};
    bit          m_err[2] = '{1'b0, 1'b0};
    logic [5:0]  m_op[2] = '{6'd0, 6'd0};
    logic [11:0] m_plan[2] = '{12'd0, 12'd0};
    int          m_plen[2] = '{0, 0};
    logic [19:0] base_tab[16];

    function automatic logic [19:0] cw(bit req, bit iord, bit mw, bit irw, bit rd, bit m2r, bit rw,
                                       bit srca, bit [1:0] srcb, bit [1:0] aop, bit [1:0] psrc, bit pcen);
        return {req, iord, mw, irw, rd, m2r, rw, srca, srcb, aop, psrc, pcen, 5'b0};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) base_tab[i] = '0;
        base_tab[P_FETCH]  = cw(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        base_tab[P_DEC]    = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        base_tab[P_MEMADR] = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        base_tab[P_MEMRD]  = cw(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        base_tab[P_MEMWB]  = cw(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        base_tab[P_MEMWR]  = cw(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        base_tab[P_REX]    = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
        base_tab[P_ALUWB]  = cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        base_tab[P_BREX]   = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        base_tab[P_IMMEX]  = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        base_tab[P_IMMWB]  = cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        base_tab[P_JEX]    = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1);
    end

    // Phases an instruction walks through after DECODE, first phase in the low nibble.
    task automatic plan_for(input logic [5:0] op, output logic [11:0] p, output int n);
        case (op)
            6'b100011: begin p = {4'(P_MEMWB), 4'(P_MEMRD), 4'(P_MEMADR)}; n = 3; end
            6'b101011: begin p = {4'd0, 4'(P_MEMWR), 4'(P_MEMADR)}; n = 2; end
            6'b000000: begin p = {4'd0, 4'(P_ALUWB), 4'(P_REX)}; n = 2; end
            6'b000100, 6'b000101: begin p = {8'd0, 4'(P_BREX)}; n = 1; end
            6'b001000, 6'b001101: begin p = {4'd0, 4'(P_IMMWB), 4'(P_IMMEX)}; n = 2; end
            6'b000010: begin p = {8'd0, 4'(P_JEX)}; n = 1; end
            default:   begin p = {8'd0, 4'(P_ERR)}; n = 1; end
        endcase
    endtask

    task automatic model_step(input int k);
        bit r;
        bit is_mem;
        r = (hs[k] != 0) ? rdy_v[k] : 1'b1;
        is_mem = (m_ph[k] == P_FETCH) || (m_ph[k] == P_MEMRD) || (m_ph[k] == P_MEMWR);
        if (!rst_n[k]) begin
            m_ph[k] = P_FETCH; m_wait[k] = 0; m_err[k] = 1'b0; m_op[k] = '0; m_plen[k] = 0;
        end else if (m_ph[k] == P_ERR) begin
            m_err[k] = 1'b1;
        end else if (is_mem && !r) begin
            m_wait[k]++;
            if (lim[k] > 0 && m_wait[k] == lim[k]) begin
                m_ph[k] = P_ERR; m_err[k] = 1'b1; m_wait[k] = 0;
            end
        end else begin
            m_wait[k] = 0;
            if (m_ph[k] == P_DEC) begin
                m_op[k] = op_v[k];
                plan_for(op_v[k], m_plan[k], m_plen[k]);
            end
            if (m_ph[k] == P_FETCH) m_ph[k] = P_DEC;
            else if (m_plen[k] > 0) begin
                m_ph[k] = int'(m_plan[k][3:0]);
                m_plan[k] = m_plan[k] >> 4;
                m_plen[k]--;
            end else m_ph[k] = P_FETCH;
            if (m_ph[k] == P_ERR) m_err[k] = 1'b1;
        end
    endtask

    function automatic logic [19:0] expect_vec(int k);
        logic [19:0] v;
        bit r;
        r = (hs[k] != 0) ? rdy_v[k] : 1'b1;
        if (!rst_n[k]) return '0;
        v = base_tab[m_ph[k]];
        if (m_ph[k] == P_FETCH) begin
            v[16] = r;
            v[B_PCEN] = r;
        end
        if (m_ph[k] == P_BREX) v[B_PCEN] = m_op[k][0] ? !zero_v[k] : zero_v[k];
        if (m_ph[k] == P_IMMEX && m_op[k] == 6'b001101) v[9:8] = 2'b11;
        v[B_ERR] = m_err[k];
        v[3:0] = 4'(m_ph[k]);
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) chk($sformatf("cycle_dut%0d", k), 32'(out_v[k]), 32'(expect_vec(k)));
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input int k, input logic [3:0] st, input string nm);
        @(negedge clk);
        last_out[k] = out_v[k];
        chk(nm, 32'(last_out[k][3:0]), 32'(st));
        @(posedge clk);
        #2;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] legal[8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};
        if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 7)];
        return 6'($urandom_range(0, 63));
    endfunction

    // ---------------- stimulus ----------------
    int stall[2] = '{0, 0};
    int wcount;
    int roll;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs_a", 32'(out_v[0]), 32'h0);
        chk("reset_outputs_b", 32'(out_v[1]), 32'h0);
        @(posedge clk); #2;
        rst_n[0] = 1'b1;

        // R-type, zero wait: 0,1,6,7,0
        op_v[0] = 6'b000000; rdy_v[0] = 1'b1;
        cyc(0, 4'd0, "r_fetch");
        cyc(0, 4'd1, "r_decode");
        cyc(0, 4'd6, "r_exec");
        chk("r_exec_regwrite", 32'(last_out[0][B_REGWRITE]), 32'd0);
        cyc(0, 4'd7, "r_aluwb");
        chk("r_aluwb_regwrite", 32'(last_out[0][B_REGWRITE]), 32'd1);
        chk("r_aluwb_regdst", 32'(last_out[0][B_REGDST]), 32'd1);
        cyc(0, 4'd0, "r_back_fetch");

        // lw with three wait cycles in MEMRD
        op_v[0] = 6'b100011;
        cyc(0, 4'd1, "lw_decode");
        cyc(0, 4'd2, "lw_memadr");
        rdy_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 4'd3, "lw_memrd_wait");
        rdy_v[0] = 1'b1;
        cyc(0, 4'd3, "lw_memrd_done");
        cyc(0, 4'd4, "lw_memwb");
        cyc(0, 4'd0, "lw_back_fetch");

        // beq/bne against both zero values
        for (int c = 0; c < 4; c++) begin
            op_v[0] = (c >= 2) ? 6'b000101 : 6'b000100;
            zero_v[0] = c[0];
            cyc(0, 4'd1, "br_decode");
            cyc(0, 4'd8, "br_exec");
            chk($sformatf("br_pcen_case%0d", c), 32'(last_out[0][B_PCEN]), 32'(c[1] ^ c[0]));
            cyc(0, 4'd0, "br_back_fetch");
        end

        // jump
        op_v[0] = 6'b000010;
        cyc(0, 4'd1, "j_decode");
        cyc(0, 4'd11, "j_exec");
        chk("j_pcen_pcsrc", 32'({last_out[0][7:6], last_out[0][B_PCEN]}), 32'b101);
        cyc(0, 4'd0, "j_back_fetch");

        // sw stalled in MEMWR, then reset drops memwrite at once
        op_v[0] = 6'b101011;
        cyc(0, 4'd1, "sw_decode");
        cyc(0, 4'd2, "sw_memadr");
        rdy_v[0] = 1'b0;
        cyc(0, 4'd5, "sw_memwr");
        chk("sw_memwrite_high", 32'(last_out[0][B_MEMWRITE]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        chk("sw_reset_memwrite", 32'(out_v[0][B_MEMWRITE]), 32'd0);
        chk("sw_reset_state", 32'(out_v[0][3:0]), 32'd0);
        @(posedge clk); #2;
        rst_n[0] = 1'b1; rdy_v[0] = 1'b1;
        cyc(0, 4'd0, "post_reset_fetch");

        // illegal opcode
        op_v[0] = 6'b111111;
        cyc(0, 4'd1, "ill_decode");
        cyc(0, 4'd15, "ill_error");
        chk("ill_outputs", 32'(last_out[0]), 32'h1F);
        cyc(0, 4'd15, "ill_error_held");
        chk("ill_err_sticky", 32'(last_out[0][B_ERR]), 32'd1);
        rst_n[0] = 1'b0;
        @(posedge clk); #2;
        rst_n[0] = 1'b1;

        // FETCH timeout after 16 wait cycles
        rdy_v[0] = 1'b0;
        for (int i = 0; i < 16; i++) cyc(0, 4'd0, "to_fetch_wait");
        cyc(0, 4'd15, "to_error");
        chk("to_err_set", 32'(last_out[0][B_ERR]), 32'd1);
        cyc(0, 4'd15, "to_error_held");
        rst_n[0] = 1'b0;
        @(posedge clk); #2;
        rst_n[0] = 1'b1;

        // ready on the 16th wait cycle completes normally
        for (int i = 0; i < 15; i++) cyc(0, 4'd0, "rescue_fetch_wait");
        rdy_v[0] = 1'b1;
        cyc(0, 4'd0, "rescue_fetch_ready");
        cyc(0, 4'd1, "rescue_decode");
        chk("rescue_err_clear", 32'(last_out[0][B_ERR]), 32'd0);
        rst_n[0] = 1'b0;

        // handshake disabled, mem_ready tied low: sw runs 0,1,2,5,0
        rst_n[1] = 1'b1; rdy_v[1] = 1'b0; op_v[1] = 6'b101011;
        wcount = 0;
        cyc(1, 4'd0, "nohs_fetch");   wcount += int'(last_out[1][B_MEMWRITE]);
        cyc(1, 4'd1, "nohs_decode");  wcount += int'(last_out[1][B_MEMWRITE]);
        cyc(1, 4'd2, "nohs_memadr");  wcount += int'(last_out[1][B_MEMWRITE]);
        cyc(1, 4'd5, "nohs_memwr");   wcount += int'(last_out[1][B_MEMWRITE]);
        cyc(1, 4'd0, "nohs_fetch2");  wcount += int'(last_out[1][B_MEMWRITE]);
        chk("nohs_memwrite_cycles", 32'(wcount), 32'd1);

        // randomized traffic on both instances
        rst_n[0] = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (m_ph[k] == P_FETCH) op_v[k] = pick_op();
                zero_v[k] = 1'($urandom_range(0, 1));
                if (stall[k] > 0) begin
                    rdy_v[k] = 1'b0;
                    stall[k]--;
                end else begin
                    rdy_v[k] = 1'b1;
                    roll = $urandom_range(0, 99);
                    stall[k] = (roll < 60) ? 0 : (roll < 90) ? $urandom_range(1, 4) : $urandom_range(13, 18);
                end
                if (!rst_n[k]) rst_n[k] = 1'b1;
                else if ((m_ph[k] == P_ERR && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0)
                    rst_n[k] = 1'b0;
            end
            @(posedge clk); #2;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
